// File: rtl/uart_pkg.sv
// Shared definitions for the FTDI channel-B UART receive path.
// Contents:
//   rx_state_t    receiver state encoding
//   DATA_BITS     payload bits per frame (8N1)
//   SYNC_STAGES   depth of the input synchroniser
//   clks_per_bit  clocks per bit cell, rounded to nearest
package uart_pkg;

  localparam int DATA_BITS   = 8;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_stream_if.sv
// Byte stream from the UART receiver to user logic.
//   rx_data   byte at the receive FIFO head
//   rx_valid  FIFO not empty
//   rx_ready  consumer takes rx_data when rx_valid && rx_ready
// master = receiver side, slave = consumer side.
import uart_pkg::*;

interface uart_rx_stream_if;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO buffering received bytes.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   push, din   write request and data; ignored when full unless a pop
//               happens in the same cycle
//   full        DEPTH entries held
//   pop         read request; ignored when empty
//   dout        registered copy of the head entry, stable until popped
//   empty       no entries held
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two in 2..16");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [WIDTH-1:0] dout_reg;

  logic          do_push, do_pop, head_is_new;
  logic [AW-1:0] rd_ptr_inc;

  assign empty      = (count_reg == '0);
  assign full       = (count_reg == (AW+1)'(DEPTH));
  assign do_pop     = pop && !empty;
  // A full FIFO can still accept a byte when the head leaves in the same cycle.
  assign do_push    = push && (!full || do_pop);
  assign rd_ptr_inc = rd_ptr_reg + AW'(1);
  // The pushed byte becomes the head when nothing else is left in front of it.
  assign head_is_new = do_push &&
                       (empty || (count_reg == (AW+1)'(1) && do_pop));

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      dout_reg   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_inc;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
      if (head_is_new) begin
        dout_reg <= din;
      end else if (do_pop) begin
        dout_reg <= mem[rd_ptr_inc];
      end
    end
  end

  assign dout = dout_reg;

endmodule

// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver for the FTDI channel-B FPGA_RXD line (BDBUS0), LSB first.
// The line is synchronised, the start bit is re-checked at mid-cell, each
// data bit and the stop bit are sampled at mid-cell, and good bytes are
// buffered in a FIFO presented on a valid/ready stream.
// Ports:
//   CLK12M     system clock
//   RESET      asynchronous active-low reset
//   BDBUS0     asynchronous serial input, idle high
//   rx         stream master (rx_data, rx_valid out; rx_ready in)
//   frame_err  one-cycle pulse when a stop bit is sampled low
//   overrun    one-cycle pulse when a finished byte is dropped (FIFO full)
//   busy       high while the receiver is in any state other than IDLE
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 12000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD),
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             CLK12M,
  input  logic             RESET,
  input  logic             BDBUS0,
  uart_rx_stream_if.master rx,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("uart_rx_stream: CLKS_PER_BIT must be in 8..65535");
  end

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_SYNC    = CNT_W'(SYNC_STAGES);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(DATA_BITS - 1);

  // ---------------- input synchroniser and edge register ----------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rxs, rxs_prev_reg, fall;

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    always_ff @(posedge CLK12M or negedge RESET) begin
      if (!RESET) begin
        sync_reg[gi] <= 1'b1;
      end else begin
        if (gi == 0) begin
          sync_reg[gi] <= BDBUS0;
        end else begin
          sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  end

  assign rxs = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge CLK12M or negedge RESET) begin
    if (!RESET) begin
      rxs_prev_reg <= 1'b1;
    end else begin
      rxs_prev_reg <= rxs;
    end
  end

  // IDLE is only ever entered with the line high, so a falling edge seen in
  // IDLE is the same event as the line being low there.
  assign fall = rxs_prev_reg & ~rxs;

  // ---------------- receiver FSM ----------------
  rx_state_t            state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 fifo_push, frame_err_next;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 frame_err_reg, overrun_reg, busy_reg;

  always_ff @(posedge CLK12M or negedge RESET) begin
    if (!RESET) begin
      state_reg <= WAIT_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    shift_next     = shift_reg;
    fifo_push      = 1'b0;
    frame_err_next = 1'b0;
    case (state_reg)
      // The counter first lets the synchroniser flush its reset value, so a
      // line still held low when reset is released is not taken as idle.
      WAIT_IDLE: begin
        if (cnt_reg != CNT_SYNC) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end else if (rxs) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (fall) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (cnt_reg == CNT_HALF_M1) begin
          if (rxs) begin
            state_next = IDLE;
          end else begin
            state_next = DATA;
            cnt_next   = '0;
            idx_next   = '0;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next            = '0;
          shift_next[idx_reg] = rxs;
          if (idx_reg == IDX_LAST) begin
            state_next = STOP;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          if (rxs) begin
            fifo_push  = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = WAIT_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = WAIT_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------- receive buffer ----------------
  assign fifo_pop = rx.rx_valid && rx.rx_ready;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (CLK12M),
    .rst_n (RESET),
    .push  (fifo_push),
    .din   (shift_reg),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  assign rx.rx_data  = fifo_dout;
  assign rx.rx_valid = !fifo_empty;

  // ---------------- status pulses ----------------
  always_ff @(posedge CLK12M or negedge RESET) begin
    if (!RESET) begin
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      frame_err_reg <= frame_err_next;
      overrun_reg   <= fifo_push && fifo_full && !fifo_pop;
      busy_reg      <= (state_next != IDLE);
    end
  end

  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign busy      = busy_reg;

endmodule
